// File: rtl/decode_repeat_ctrl.sv
// REP/REPE/REPNE iteration controller: replays one decoded string instruction once per
// ECX/CX count, writes back the decremented count, and opens an interrupt window between beats.
module decode_repeat_ctrl #(
    parameter int unsigned PAYW   = 128,
    parameter int unsigned IADDRW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PAYW-1:0] in_payload,
    input  logic [1:0]      in_rep,
    input  logic            in_cmp,
    input  logic            in_addr16,
    input  logic [31:0]     ecx_register,
    input  logic            zf_valid,
    input  logic            zf,
    input  logic            pending_int,
    output logic            hold_int,
    output logic            int_window,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PAYW-1:0] out_payload,
    output logic            out_last,
    output logic            wb_valid,
    output logic [2:0]      wb_reg,
    output logic [31:0]     wb_data,
    output logic [2:0]      wb_size
);

    typedef enum logic [1:0] {StIdle, StIter, StWaitFlag, StIntHold} state_e;

    state_e      r_state;
    logic [31:0] r_count;

    logic [31:0] w_eff_count;
    logic        w_rep;
    logic        w_last;
    logic        w_zf_term;
    logic [15:0] w_cx_dec;

    assign w_eff_count = in_addr16 ? {16'b0, ecx_register[15:0]} : ecx_register;
    assign w_rep       = (in_rep != 2'b00);
    assign w_last      = (r_count == 32'd1);
    assign w_zf_term   = ((in_rep == 2'b10) && !zf) || ((in_rep == 2'b11) && zf);
    assign w_cx_dec    = r_count[15:0] - 16'd1;

    assign wb_reg   = 3'b001;
    assign wb_size  = in_addr16 ? 3'd2 : 3'd3;
    assign hold_int = pending_int && ((r_state == StIter) || (r_state == StWaitFlag)) && !flush;

    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        wb_valid   = 1'b0;
        int_window = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_rep) begin
                    out_valid = in_valid;
                    in_ready  = out_ready;
                    out_last  = 1'b1;
                end else if (in_valid && (w_eff_count == 32'd0)) begin
                    in_ready = 1'b1;
                end
            end
            StIter: begin
                out_valid = 1'b1;
                out_last  = w_last;
                wb_valid  = out_ready;
                in_ready  = out_ready && w_last;
            end
            StWaitFlag: begin
                in_ready = zf_valid && w_zf_term;
            end
            StIntHold: begin
                int_window = 1'b1;
            end
            default: ;
        endcase
        if (flush) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            wb_valid  = 1'b0;
        end
    end

    // Gated so idle outputs read as zero rather than stale payload or count-1.
    assign out_payload = out_valid ? in_payload : '0;
    assign wb_data     = !wb_valid ? 32'd0 :
                         in_addr16 ? {ecx_register[31:16], w_cx_dec} : (r_count - 32'd1);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state <= StIdle;
            r_count <= 32'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_rep && in_valid && (w_eff_count != 32'd0)) begin
                        r_count <= w_eff_count;
                        r_state <= StIter;
                    end
                end
                StIter: begin
                    if (out_ready) begin
                        r_count <= r_count - 32'd1;
                        if (w_last) begin
                            r_state <= StIdle;
                        end else if (in_cmp && in_rep[1]) begin
                            r_state <= StWaitFlag;
                        end else if (pending_int) begin
                            r_state <= StIntHold;
                        end
                    end
                end
                StWaitFlag: begin
                    if (zf_valid) begin
                        if (w_zf_term) begin
                            r_state <= StIdle;
                        end else if (pending_int) begin
                            r_state <= StIntHold;
                        end else begin
                            r_state <= StIter;
                        end
                    end
                end
                // Only a flush leaves; stage 0 refetches after IRET with the updated ECX.
                StIntHold: r_state <= StIntHold;
                default:   r_state <= StIdle;
            endcase
        end
    end

endmodule
